// File: rtl/router_output_channel.sv
// Egress side of a mesh router port: two 1-flit VC buffers drained onto the
// link, with writes and transmits interleaved by the global polarity phase.
module router_output_channel #(
    parameter int DATA_WIDTH = 64,
    parameter int VC_BIT     = 63
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  polarity,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready_even,
    output logic                  ready_odd,
    input  logic                  ready_in,
    output logic                  send_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  wr_err
);

    logic [DATA_WIDTH-1:0] buf_even_q, buf_even_d;
    logic [DATA_WIDTH-1:0] buf_odd_q, buf_odd_d;
    logic                  full_even_q, full_even_d;
    logic                  full_odd_q, full_odd_d;
    logic                  send_q, send_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  wr_err_q, wr_err_d;

    logic vc;
    logic wr_vc_ok;
    logic wr_tgt_full;
    logic wr_ok;
    logic tx_full;
    logic tx_go;

    // polarity 0: write odd / transmit even; polarity 1: the reverse
    assign vc          = data_in[VC_BIT];
    assign wr_vc_ok    = (vc == !polarity);
    assign wr_tgt_full = polarity ? full_even_q : full_odd_q;
    assign wr_ok       = wr_en && wr_vc_ok && !wr_tgt_full;
    assign tx_full     = polarity ? full_odd_q : full_even_q;
    assign tx_go       = tx_full && ready_in;

    always_comb begin
        buf_even_d  = buf_even_q;
        buf_odd_d   = buf_odd_q;
        full_even_d = full_even_q;
        full_odd_d  = full_odd_q;
        send_d      = 1'b0;
        data_d      = '0;
        wr_err_d    = wr_err_q;

        if (wr_ok) begin
            if (polarity) begin
                buf_even_d  = data_in;
                full_even_d = 1'b1;
            end else begin
                buf_odd_d  = data_in;
                full_odd_d = 1'b1;
            end
        end else if (wr_en) begin
            wr_err_d = 1'b1;
        end

        if (tx_go) begin
            send_d = 1'b1;
            if (polarity) begin
                data_d     = buf_odd_q;
                full_odd_d = 1'b0;
            end else begin
                data_d      = buf_even_q;
                full_even_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_even_q  <= '0;
            buf_odd_q   <= '0;
            full_even_q <= 1'b0;
            full_odd_q  <= 1'b0;
            send_q      <= 1'b0;
            data_q      <= '0;
            wr_err_q    <= 1'b0;
        end else begin
            buf_even_q  <= buf_even_d;
            buf_odd_q   <= buf_odd_d;
            full_even_q <= full_even_d;
            full_odd_q  <= full_odd_d;
            send_q      <= send_d;
            data_q      <= data_d;
            wr_err_q    <= wr_err_d;
        end
    end

    assign ready_even = !full_even_q;
    assign ready_odd  = !full_odd_q;
    assign send_out   = send_q;
    assign data_out   = data_q;
    assign wr_err     = wr_err_q;

endmodule
